// File: rtl/rv_arb_pkg.sv
// Shared types, width helper and default sizes for the ready/valid arbiter FIFO
// and its bench.
package rv_arb_pkg;

  typedef enum logic [0:0] {
    ARB_RR,
    ARB_FIXED
  } arb_mode_e;

  localparam int unsigned DefNumCh  = 4;
  localparam int unsigned DefDataW  = 32;
  localparam int unsigned DefDepth  = 4;

  // Channel-index width; a single channel still needs one bit to carry out_chan.
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read view and registered
// occupancy count.
module rv_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/rv_rr_arbiter_fifo.sv
// N buffered ready/valid input channels merged onto one registered output
// stream, arbitrated round-robin or fixed priority, tagged with source channel.
module rv_rr_arbiter_fifo
  import rv_arb_pkg::*;
#(
  parameter int unsigned NUM_CH   = DefNumCh,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned DEPTH    = DefDepth,
  parameter arb_mode_e   ARB_MODE = ARB_RR,
  localparam int unsigned CH_W    = ch_w(NUM_CH),
  localparam int unsigned FW      = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic [NUM_CH*FW-1:0]     fill
);

  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("rv_rr_arbiter_fifo: NUM_CH must be in 1..16");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rv_rr_arbiter_fifo: DEPTH must be a power of two >= 2");
  end

  logic [DATA_W-1:0] fifo_dout [NUM_CH];
  logic [NUM_CH-1:0] fifo_full, fifo_empty, nonempty, pop_vec;

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   grant;
  logic              arb_found;
  logic              can_load, load;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CH_W-1:0]   out_chan_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rv_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_valid[i] & ~fifo_full[i]),
      .pop   (pop_vec[i]),
      .din   (in_data[i*DATA_W +: DATA_W]),
      .dout  (fifo_dout[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i]),
      .count (fill[i*FW +: FW])
    );
  end

  // in_ready depends only on registered counts, never on out_ready.
  assign in_ready = ~fifo_full;
  assign nonempty = ~fifo_empty;

  assign can_load = ~out_valid_q | out_ready;
  assign load     = can_load & arb_found;

  always_comb begin
    int unsigned idx;
    grant     = '0;
    arb_found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = (ARB_MODE == ARB_RR) ? 32'(ptr_q) + k : k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!arb_found && nonempty[idx]) begin
        arb_found = 1'b1;
        grant     = CH_W'(idx);
      end
    end
  end

  always_comb begin
    pop_vec = '0;
    if (load) pop_vec[grant] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (load) ptr_d = (32'(grant) + 1 >= NUM_CH) ? '0 : grant + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (ARB_MODE == ARB_RR) begin
      ptr_q <= ptr_d;
    end
  end

  // Output register: data and tag hold while stalled; valid drops when nothing is buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
    end else if (can_load) begin
      out_valid_q <= arb_found;
      if (arb_found) begin
        out_data_q <= fifo_dout[grant];
        out_chan_q <= grant;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule
